// File: rtl/ddr2_sequencer_avl_arbiter.sv
// ---------------------------------------------------------------------------
// ddr2_sequencer_avl_arbiter
//
// Purpose:
//   Shares one Avalon-MM slave port between two masters: the sequencer CPU
//   (m0) and a debug/calibration-override master (m1). Ownership is granted
//   round-robin per transaction and held until the slave drops waitrequest.
//   A watchdog aborts a transaction the slave never completes. The aborted
//   master is released with a fixed read word, and a sticky error flag is set.
//
// Ports:
//   avl_clk, avl_reset        clock, asynchronous active-high reset
//   mN_address/write/writedata/read      master N request side (N = 0, 1)
//   mN_readdata/waitrequest              master N response side
//   s_address/write/writedata/read       slave request side
//   s_readdata/waitrequest               slave response side
//   grant                     one-hot current owner (bit0 = m0, bit1 = m1)
//   timeout_err               sticky abort flag, cleared only by reset
// ---------------------------------------------------------------------------
module ddr2_sequencer_avl_arbiter #(
    parameter int                        AVL_DATA_WIDTH = 32,
    parameter int                        AVL_ADDR_WIDTH = 16,
    parameter int                        TIMEOUT_CYCLES = 1024,
    parameter logic [AVL_DATA_WIDTH-1:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                      avl_clk,
    input  logic                      avl_reset,

    input  logic [AVL_ADDR_WIDTH-1:0] m0_address,
    input  logic                      m0_write,
    input  logic [AVL_DATA_WIDTH-1:0] m0_writedata,
    input  logic                      m0_read,
    output logic [AVL_DATA_WIDTH-1:0] m0_readdata,
    output logic                      m0_waitrequest,

    input  logic [AVL_ADDR_WIDTH-1:0] m1_address,
    input  logic                      m1_write,
    input  logic [AVL_DATA_WIDTH-1:0] m1_writedata,
    input  logic                      m1_read,
    output logic [AVL_DATA_WIDTH-1:0] m1_readdata,
    output logic                      m1_waitrequest,

    output logic [AVL_ADDR_WIDTH-1:0] s_address,
    output logic                      s_write,
    output logic [AVL_DATA_WIDTH-1:0] s_writedata,
    output logic                      s_read,
    input  logic [AVL_DATA_WIDTH-1:0] s_readdata,
    input  logic                      s_waitrequest,

    output logic [1:0]                grant,
    output logic                      timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    // The watchdog compares against the last stalled cycle index so that
    // exactly TIMEOUT_CYCLES stalled owned cycles precede the abort.
    localparam bit          WDOG_EN      = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TIMEOUT_LAST = WDOG_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        timeout_err_q, timeout_err_d;

    // Master-side signals gathered into arrays so the muxes index by owner.
    logic [1:0]                req;
    logic [AVL_ADDR_WIDTH-1:0] m_addr  [2];
    logic [AVL_DATA_WIDTH-1:0] m_wdata [2];
    logic [1:0]                m_wr;
    logic [1:0]                m_rd;
    logic [AVL_DATA_WIDTH-1:0] m_rdata [2];
    logic [1:0]                m_wait;

    assign m_addr[0]  = m0_address;
    assign m_addr[1]  = m1_address;
    assign m_wdata[0] = m0_writedata;
    assign m_wdata[1] = m1_writedata;
    assign m_wr       = {m1_write, m0_write};
    assign m_rd       = {m1_read,  m0_read};
    assign req        = m_wr | m_rd;

    logic bus_active;
    logic abort_active;
    logic own_idx;
    logic owner_req;

    assign bus_active   = (state_q == ST_OWN0) || (state_q == ST_OWN1);
    assign abort_active = (state_q == ST_ABORT);
    // grant_q is one-hot whenever it is consulted, so bit1 is the owner index.
    assign own_idx      = grant_q[1];
    assign owner_req    = req[own_idx];

    // ------------------------------------------------------------------
    // Per-master response muxes, driven from the registered grant.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master_rsp
            always_comb begin
                m_wait[gi]  = 1'b1;
                m_rdata[gi] = '0;
                if (grant_q[gi]) begin
                    if (abort_active) begin
                        m_wait[gi]  = 1'b0;
                        m_rdata[gi] = TIMEOUT_RDATA;
                    end else if (bus_active) begin
                        m_wait[gi]  = s_waitrequest;
                        m_rdata[gi] = s_readdata;
                    end
                end
            end
        end
    endgenerate

    assign m0_waitrequest = m_wait[0];
    assign m1_waitrequest = m_wait[1];
    assign m0_readdata    = m_rdata[0];
    assign m1_readdata    = m_rdata[1];

    // ------------------------------------------------------------------
    // Slave request mux: only an OWN state forwards the owner's request.
    // IDLE and ABORT present an all-zero bus.
    // ------------------------------------------------------------------
    assign s_address   = bus_active ? m_addr[own_idx]  : '0;
    assign s_writedata = bus_active ? m_wdata[own_idx] : '0;
    assign s_write     = bus_active & m_wr[own_idx];
    assign s_read      = bus_active & m_rd[own_idx];

    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic winner;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        stall_cnt_d   = stall_cnt_q;
        timeout_err_d = timeout_err_q;
        winner        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    // With both requesting, the master not served last wins.
                    // A lone requester wins outright.
                    winner       = (req == 2'b11) ? ~last_grant_q : req[1];
                    state_d      = winner ? ST_OWN1 : ST_OWN0;
                    grant_d      = winner ? 2'b10 : 2'b01;
                    last_grant_d = winner;
                    stall_cnt_d  = '0;
                end
            end

            ST_OWN0, ST_OWN1: begin
                if (!owner_req || !s_waitrequest) begin
                    // Completion, or the owner withdrew its request.
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                end else begin
                    stall_cnt_d = 16'(stall_cnt_q + 16'd1);
                    if (WDOG_EN && (stall_cnt_q == TIMEOUT_LAST)) begin
                        state_d       = ST_ABORT;
                        timeout_err_d = 1'b1;
                    end
                end
            end

            ST_ABORT: begin
                // grant is held through ABORT so the release reaches the
                // aborted master; it clears on return to IDLE.
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge avl_clk or posedge avl_reset) begin
        if (avl_reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= 2'b00;
            last_grant_q  <= 1'b1;
            stall_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            stall_cnt_q   <= stall_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_ddr2_sequencer_avl_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr2_sequencer_avl_arbiter
//
// Directed bench for the two-master Avalon arbiter. Built with a watchdog of
// 8 cycles. Inputs change 1 ns after the rising edge, and outputs are sampled
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_ddr2_sequencer_avl_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          avl_reset;
    logic [AW-1:0] m0_address, m1_address, s_address;
    logic          m0_write, m1_write, m0_read, m1_read;
    logic [DW-1:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
    logic          m0_waitrequest, m1_waitrequest;
    logic          s_write, s_read, s_waitrequest;
    logic [DW-1:0] s_writedata, s_readdata;
    logic [1:0]    grant;
    logic          timeout_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ddr2_sequencer_avl_arbiter #(
        .AVL_DATA_WIDTH (DW),
        .AVL_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_RDATA  (32'hDEAD_BEEF)
    ) dut (
        .avl_clk        (clk),
        .avl_reset      (avl_reset),
        .m0_address     (m0_address),
        .m0_write       (m0_write),
        .m0_writedata   (m0_writedata),
        .m0_read        (m0_read),
        .m0_readdata    (m0_readdata),
        .m0_waitrequest (m0_waitrequest),
        .m1_address     (m1_address),
        .m1_write       (m1_write),
        .m1_writedata   (m1_writedata),
        .m1_read        (m1_read),
        .m1_readdata    (m1_readdata),
        .m1_waitrequest (m1_waitrequest),
        .s_address      (s_address),
        .s_write        (s_write),
        .s_writedata    (s_writedata),
        .s_read         (s_read),
        .s_readdata     (s_readdata),
        .s_waitrequest  (s_waitrequest),
        .grant          (grant),
        .timeout_err    (timeout_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    logic [DW-1:0] exp_rd;

    initial begin
        avl_reset     = 1'b1;
        m0_address    = '0; m1_address   = '0;
        m0_write      = 1'b0; m1_write   = 1'b0;
        m0_read       = 1'b0; m1_read    = 1'b0;
        m0_writedata  = '0; m1_writedata = '0;
        s_readdata    = '0;
        s_waitrequest = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #2;
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_m0_wait", 64'(m0_waitrequest), 64'h1);
        chk("rst_m1_wait", 64'(m1_waitrequest), 64'h1);
        chk("rst_s_write", 64'(s_write), 64'h0);
        chk("rst_s_read", 64'(s_read), 64'h0);
        chk("rst_terr", 64'(timeout_err), 64'h0);
        chk("rst_m0_rdata", 64'(m0_readdata), 64'h0);
        avl_reset = 1'b0;

        // ---------------- both masters reading, round-robin ----------------
        step();
        m0_read = 1'b1; m1_read = 1'b1;
        m0_address = 16'h0100; m1_address = 16'h0200;
        s_waitrequest = 1'b0;
        for (int n = 0; n < 4; n++) begin
            if (n > 0) step();
            smp();
            chk("rr_idle_grant", 64'(grant), 64'h0);
            chk("rr_idle_s_read", 64'(s_read), 64'h0);
            step();
            s_readdata = 32'hA5A5_0000 + 32'(n);
            exp_rd = 32'hA5A5_0000 + 32'(n);
            smp();
            if (n % 2 == 0) begin
                chk("rr_grant_m0", 64'(grant), 64'h1);
                chk("rr_addr_m0", 64'(s_address), 64'h0100);
                chk("rr_m0_rdata", 64'(m0_readdata), 64'(exp_rd));
                chk("rr_m0_wait", 64'(m0_waitrequest), 64'h0);
                chk("rr_m1_wait", 64'(m1_waitrequest), 64'h1);
                chk("rr_m1_rdata0", 64'(m1_readdata), 64'h0);
            end else begin
                chk("rr_grant_m1", 64'(grant), 64'h2);
                chk("rr_addr_m1", 64'(s_address), 64'h0200);
                chk("rr_m1_rdata", 64'(m1_readdata), 64'(exp_rd));
                chk("rr_m1_wait", 64'(m1_waitrequest), 64'h0);
                chk("rr_m0_wait", 64'(m0_waitrequest), 64'h1);
                chk("rr_m0_rdata0", 64'(m0_readdata), 64'h0);
            end
            chk("rr_s_read", 64'(s_read), 64'h1);
            $display("txn rr n=%0d grant=%0b rdata=%h", n, grant, exp_rd);
        end
        step();
        m0_read = 1'b0; m1_read = 1'b0;
        smp();
        chk("rr_end_grant", 64'(grant), 64'h0);

        // ---------------- m0 write with 2 stalled cycles ----------------
        step();
        m0_address = 16'h0010; m0_writedata = 32'h1234_5678;
        m0_write = 1'b1; s_waitrequest = 1'b1;
        smp();
        chk("wr_idle_s_write", 64'(s_write), 64'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            if (k == 2) s_waitrequest = 1'b0;
            smp();
            chk("wr_s_write", 64'(s_write), 64'h1);
            chk("wr_s_addr", 64'(s_address), 64'h0010);
            chk("wr_s_wdata", 64'(s_writedata), 64'h1234_5678);
            chk("wr_grant", 64'(grant), 64'h1);
            chk("wr_m0_wait", 64'(m0_waitrequest), (k == 2) ? 64'h0 : 64'h1);
            chk("wr_m1_wait", 64'(m1_waitrequest), 64'h1);
        end
        step();
        m0_write = 1'b0;
        smp();
        chk("wr_end_grant", 64'(grant), 64'h0);
        chk("wr_end_s_write", 64'(s_write), 64'h0);
        $display("txn write m0 addr=0010 data=12345678 done");

        // ---------------- m0 re-requesting, m1 requests once ----------------
        step();
        m0_write = 1'b1; m0_address = 16'h0020; s_waitrequest = 1'b1;
        step();
        m1_read = 1'b1; m1_address = 16'h0030;
        smp();
        chk("fair_m0_own", 64'(grant), 64'h1);
        chk("fair_m1_wait", 64'(m1_waitrequest), 64'h1);
        step();
        s_waitrequest = 1'b0;
        smp();
        chk("fair_m0_done", 64'(m0_waitrequest), 64'h0);
        step();
        smp();
        chk("fair_idle", 64'(grant), 64'h0);
        step();
        s_readdata = 32'h0000_3333;
        smp();
        chk("fair_m1_grant", 64'(grant), 64'h2);
        chk("fair_m1_rdata", 64'(m1_readdata), 64'h3333);
        chk("fair_m1_wait", 64'(m1_waitrequest), 64'h0);
        chk("fair_m0_held", 64'(m0_waitrequest), 64'h1);
        chk("fair_s_addr", 64'(s_address), 64'h0030);
        step();
        m1_read = 1'b0;
        smp();
        chk("fair_idle2", 64'(grant), 64'h0);
        step();
        smp();
        chk("fair_m0_again", 64'(grant), 64'h1);
        step();
        m0_write = 1'b0;
        smp();
        chk("fair_end", 64'(grant), 64'h0);
        $display("txn fairness m0,m1,m0 done");

        // ---------------- watchdog abort on m1 read ----------------
        step();
        m1_read = 1'b1; m1_address = 16'h0040; s_waitrequest = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            smp();
            chk("wd_grant", 64'(grant), 64'h2);
            chk("wd_m1_wait", 64'(m1_waitrequest), 64'h1);
            chk("wd_terr_low", 64'(timeout_err), 64'h0);
        end
        step();
        smp();
        chk("wd_abort_wait", 64'(m1_waitrequest), 64'h0);
        chk("wd_abort_rdata", 64'(m1_readdata), 64'hDEAD_BEEF);
        chk("wd_abort_s_read", 64'(s_read), 64'h0);
        chk("wd_abort_terr", 64'(timeout_err), 64'h1);
        chk("wd_abort_m0_wait", 64'(m0_waitrequest), 64'h1);
        step();
        m1_read = 1'b0; s_waitrequest = 1'b0;
        smp();
        chk("wd_post_wait", 64'(m1_waitrequest), 64'h1);
        chk("wd_post_grant", 64'(grant), 64'h0);
        chk("wd_post_terr", 64'(timeout_err), 64'h1);
        step();
        m0_write = 1'b1; m0_address = 16'h0050;
        step();
        smp();
        chk("wd_good_grant", 64'(grant), 64'h1);
        chk("wd_good_wait", 64'(m0_waitrequest), 64'h0);
        step();
        m0_write = 1'b0;
        smp();
        chk("wd_sticky", 64'(timeout_err), 64'h1);
        $display("txn abort m1 read rdata=deadbeef timeout_err=%0b", timeout_err);

        // ---------------- reset during stalled m0 write ----------------
        step();
        m0_write = 1'b1; m0_address = 16'h0060; s_waitrequest = 1'b1;
        step();
        smp();
        chk("rm_s_write", 64'(s_write), 64'h1);
        @(posedge clk);
        #2;
        avl_reset = 1'b1;
        #1;
        chk("rm_s_write_drop", 64'(s_write), 64'h0);
        chk("rm_grant", 64'(grant), 64'h0);
        chk("rm_m0_wait", 64'(m0_waitrequest), 64'h1);
        chk("rm_terr_clr", 64'(timeout_err), 64'h0);
        m0_write = 1'b0;
        @(negedge clk);
        avl_reset = 1'b0;
        step();
        m0_write = 1'b1; m1_read = 1'b1; s_waitrequest = 1'b0;
        smp();
        chk("rm_idle", 64'(grant), 64'h0);
        step();
        smp();
        chk("rm_first_m0", 64'(grant), 64'h1);
        step();
        m0_write = 1'b0;
        smp();
        chk("rm_idle2", 64'(grant), 64'h0);
        step();
        smp();
        chk("rm_then_m1", 64'(grant), 64'h2);
        step();
        m1_read = 1'b0;
        smp();
        chk("rm_end", 64'(grant), 64'h0);
        $display("txn reset mid-write, then m0,m1 done");

        // ---------------- m1 withdraws a stalled read ----------------
        step();
        m1_read = 1'b1; s_waitrequest = 1'b1;
        step();
        smp();
        chk("dr_grant", 64'(grant), 64'h2);
        step();
        m1_read = 1'b0;
        step();
        smp();
        chk("dr_idle", 64'(grant), 64'h0);
        chk("dr_terr", 64'(timeout_err), 64'h0);
        step();
        m0_read = 1'b1; m0_address = 16'h0070; s_waitrequest = 1'b0;
        s_readdata = 32'h0000_6666;
        step();
        smp();
        chk("dr_m0_grant", 64'(grant), 64'h1);
        chk("dr_m0_rdata", 64'(m0_readdata), 64'h6666);
        chk("dr_m0_wait", 64'(m0_waitrequest), 64'h0);
        step();
        m0_read = 1'b0;
        $display("txn m1 drop then m0 read rdata=%h", 32'h0000_6666);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
